// File: rtl/seqdet_frame_ctrl.sv
// Round-robin frame sequencer in front of a serial, overlapping pattern detector.
// Two requesters share one detector. Each granted word is shifted through MSB-first and its matches are counted.
module seqdet_frame_ctrl #(
  parameter int               DATA_W    = 16,
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 5,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1010)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              x_out,
  output logic              y,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [1:0]        state_dbg
);

  localparam int NB_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   pat;
  logic [DATA_W-1:0]  shreg;
  logic [PAT_W-2:0]   hist;
  logic [NB_W-1:0]    nbits;
  logic               rr_last;   // requester served most recently
  logic               start, sel1, last_bit, hit, x_bit;
  logic [PAT_W-1:0]   window;

  assign x_bit     = shreg[DATA_W-1];
  assign window    = {hist, x_bit};
  assign x_out     = (state == S_SHIFT) && x_bit;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Handshake: a requester holds req high until it sees its one-cycle gnt.
  // It must drop req during that gnt cycle. If req is still high when the block returns to IDLE, a new frame starts.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    sel1      = 1'b0;
    last_bit  = 1'b0;
    hit       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          start     = 1'b1;
          // On a tie, grant the requester that was not served last.
          sel1      = req1 && (!req0 || !rr_last);
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        hit      = (window == pat) && (nbits >= NB_W'(PAT_W - 1));
        last_bit = (nbits == NB_W'(DATA_W - 1));
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat       <= RESET_PAT;
      shreg     <= '0;
      hist      <= '0;
      nbits     <= '0;
      rr_last   <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      y         <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      match_cnt <= '0;
    end else begin
      gnt0 <= start && !sel1;
      gnt1 <= start && sel1;
      y    <= hit;
      done <= last_bit;
      // A pattern written on the grant edge is already in place for the first bit.
      if (state == S_IDLE && cfg_we) pat <= cfg_pat;
      if (start) begin
        shreg     <= sel1 ? data1 : data0;
        hist      <= '0;
        nbits     <= '0;
        match_cnt <= '0;
        done_id   <= sel1;
        rr_last   <= sel1;
      end else if (state == S_SHIFT) begin
        shreg <= {shreg[DATA_W-2:0], 1'b0};
        hist  <= window[PAT_W-2:0];
        nbits <= nbits + NB_W'(1);
        if (hit) match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seqdet_frame_ctrl.sv
// Directed bench for seqdet_frame_ctrl covering arbitration, pattern config, frame timing and mid-frame abort.
// The expected match counts are worked out by hand.
module tb_seqdet_frame_ctrl;

  localparam int DW = 16;
  localparam int PW = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [PW-1:0] cfg_pat;
  logic          req0, req1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, busy, x_out, y, done, done_id;
  logic [CW-1:0] match_cnt;
  logic [1:0]    state_dbg;

  int checks = 0;
  int fails  = 0;

  seqdet_frame_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW), .RESET_PAT(4'b1010)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .x_out(x_out), .y(y),
    .done(done), .done_id(done_id), .match_cnt(match_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called in the grant cycle (one step after E0). Returns one step after E(DW+1), with the block back in IDLE.
  task automatic frame_check(input string name, input logic exp_id, input logic [DW-1:0] d,
                             input int exp_y, input int cfg_at);
    int   ycnt, done_cyc;
    logic xbad, gbad, d_id;
    logic [CW-1:0] d_cnt;
    ycnt = 0; done_cyc = -1; xbad = 1'b0; gbad = 1'b0; d_id = 1'b0; d_cnt = '0;
    checks++;
    if ({gnt0, gnt1, busy} !== {~exp_id, exp_id, 1'b1}) begin
      fails++;
      $display("FAIL %s_grant: gnt0/gnt1/busy=%b%b%b required %b%b1", name, gnt0, gnt1, busy, ~exp_id, exp_id);
    end
    for (int c = 0; c <= DW + 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      cfg_we = (c == cfg_at);
      if (c == cfg_at) cfg_pat = 4'b0000;
      if (c == 1 && (gnt0 || gnt1)) gbad = 1'b1;
      if (c < DW && x_out !== d[DW-1-c]) xbad = 1'b1;
      if (y === 1'b1) ycnt++;
      if (done === 1'b1) begin
        done_cyc = c; d_id = done_id; d_cnt = match_cnt;
        break;
      end
    end
    cfg_we = 1'b0;
    checks++;
    if (gbad) begin fails++; $display("FAIL %s_gnt_pulse: grant still high a cycle later, required one-cycle pulse", name); end
    checks++;
    if (xbad) begin fails++; $display("FAIL %s_x_seq: x_out bit sequence differs from word %h", name, d); end
    checks++;
    if (done_cyc != DW) begin fails++; $display("FAIL %s_done_time: done at cycle %0d required %0d", name, done_cyc, DW); end
    checks++;
    if (ycnt != exp_y) begin fails++; $display("FAIL %s_y_pulses: got %0d required %0d", name, ycnt, exp_y); end
    checks++;
    if ({d_id, d_cnt} !== {exp_id, CW'(exp_y)}) begin
      fails++;
      $display("FAIL %s_result: done_id=%b match_cnt=%0d required %b/%0d", name, d_id, d_cnt, exp_id, exp_y);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, match_cnt} !== {1'b0, 1'b0, CW'(exp_y)}) begin
      fails++;
      $display("FAIL %s_idle: busy=%b done=%b match_cnt=%0d required 0/0/%0d", name, busy, done, match_cnt, exp_y);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cfg_we = 1'b0; cfg_pat = '0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, busy, x_out, y, done, done_id, match_cnt, state_dbg} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required all zero",
               {gnt0, gnt1, busy, x_out, y, done, done_id, match_cnt, state_dbg});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, busy, done, match_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_idle: got %b required all zero", {gnt0, gnt1, busy, done, match_cnt});
    end
  endtask

  // AAAA with 1010 gives 7 matches. The word 0000 is then granted on E(DW+2), the earliest possible edge.
  task automatic test_basic();
    data0 = 16'hAAAA; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    frame_check("basic", 1'b0, 16'hAAAA, 7, -1);
    data0 = 16'h0000; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    frame_check("back_to_back", 1'b0, 16'h0000, 0, -1);
  endtask

  // With both requests held continuously, grants must alternate 0,1,0,1.
  // The word 5555 with pattern 1010 gives 6 matches.
  task automatic test_tie();
    apply_reset();
    data0 = 16'hAAAA; data1 = 16'h5555;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1;
    frame_check("tie_a", 1'b0, 16'hAAAA, 7, -1);
    @(posedge clk); #1;
    frame_check("tie_b", 1'b1, 16'h5555, 6, -1);
    @(posedge clk); #1;
    frame_check("tie_c", 1'b0, 16'hAAAA, 7, -1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    frame_check("tie_d", 1'b1, 16'h5555, 6, -1);
    @(posedge clk); #1;
    checks++;
    if ({busy, gnt0, gnt1} !== 3'b000) begin
      fails++; $display("FAIL tie_quiet: busy/gnt0/gnt1=%b required 000", {busy, gnt0, gnt1});
    end
  endtask

  // The pattern write lands on the grant edge itself. A later write during SHIFT must be ignored.
  task automatic test_cfg();
    cfg_we = 1'b1; cfg_pat = 4'b1111; data0 = 16'hFFFF; req0 = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; req0 = 1'b0;
    frame_check("cfg", 1'b0, 16'hFFFF, 13, -1);
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    frame_check("cfg_ignored", 1'b0, 16'hFFFF, 13, 5);
  endtask

  // The pattern is set to 0101 before the abort. A count of 7 afterwards shows it went back to 1010.
  task automatic test_abort();
    cfg_we = 1'b1; cfg_pat = 4'b0101;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    data0 = 16'hAAAA; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    checks++;
    if (match_cnt !== CW'(2)) begin
      fails++; $display("FAIL abort_pre_cnt: match_cnt=%0d required 2", match_cnt);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, busy, x_out, y, done, done_id, match_cnt} !== '0) begin
      fails++;
      $display("FAIL abort_clear: got %b required all zero", {gnt0, gnt1, busy, x_out, y, done, done_id, match_cnt});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    begin
      logic seen_done;
      seen_done = 1'b0;
      repeat (4) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1; end
      checks++;
      if (seen_done) begin fails++; $display("FAIL abort_no_done: activity seen after abort, required none"); end
    end
    data1 = 16'hAAAA; req1 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0;
    frame_check("post_abort", 1'b1, 16'hAAAA, 7, -1);
  endtask

  // Two back-to-back frames whose bits would form 1010 across the frame boundary.
  task automatic test_cross_frame();
    data0 = 16'h0001; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    frame_check("cross_a", 1'b0, 16'h0001, 0, -1);
    data0 = 16'h4000; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    frame_check("cross_b", 1'b0, 16'h4000, 0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_cfg();
    test_abort();
    test_cross_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
